// File: rtl/dac_parallel_responder.sv
// Receiving end of a dual 8-bit parallel DAC write bus: synchronizes the bus, decodes
// CS/WR writes into input registers A/B, and models LDAC transfer, CLR and power-down.
module dac_parallel_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [7:0]       DB,
    input  logic             CS,
    input  logic             WR,
    input  logic             AB,
    input  logic             PD,
    input  logic             LDAC,
    input  logic             CLR,
    output logic [7:0]       VoutA,
    output logic [7:0]       VoutB,
    output logic [7:0]       InA,
    output logic [7:0]       InB,
    output logic [CNT_W-1:0] WrCntA,
    output logic [CNT_W-1:0] WrCntB,
    output logic             WrDone,
    output logic             ProtoErr
);

    // Bus word layout: {DB, AB, CS, WR, LDAC, CLR, PD}; DB/AB share the control delay.
    localparam int unsigned BUS_W = 14;
    localparam logic [BUS_W-1:0] IDLE_BUS = {8'h00, 1'b0, 5'b11111};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEL,
        ST_STROBE
    } state_t;

    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic [BUS_W-1:0] s_bus;
    logic [7:0]       s_db;
    logic             s_ab, s_cs, s_wr, s_ldac, s_clr, s_pd;

    state_t           state_q, state_d;
    logic             capture, abort;

    logic [7:0]       in_a_q, in_a_d, in_b_q, in_b_d;
    logic [7:0]       dac_a_q, dac_a_d, dac_b_q, dac_b_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic             done_q, perr_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= IDLE_BUS;
            end
        end else begin
            sync_q[0] <= {DB, AB, CS, WR, LDAC, CLR, PD};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s_bus  = sync_q[SYNC_STAGES-1];
    assign s_db   = s_bus[13:6];
    assign s_ab   = s_bus[5];
    assign s_cs   = s_bus[4];
    assign s_wr   = s_bus[3];
    assign s_ldac = s_bus[2];
    assign s_clr  = s_bus[1];
    assign s_pd   = s_bus[0];

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!s_cs && s_wr) state_d = ST_SEL;
            end
            ST_SEL: begin
                if (s_cs)       state_d = ST_IDLE;
                else if (!s_wr) state_d = ST_STROBE;
            end
            ST_STROBE: begin
                // WR seen high completes the write whether or not CS rose in the same sample.
                if (s_wr) begin
                    capture = 1'b1;
                    state_d = s_cs ? ST_IDLE : ST_SEL;
                end else if (s_cs) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_a_d  = in_a_q;
        in_b_d  = in_b_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (capture) begin
            if (s_ab) begin
                in_b_d  = s_db;
                cnt_b_d = cnt_b_q + CNT_W'(1);
            end else begin
                in_a_d  = s_db;
                cnt_a_d = cnt_a_q + CNT_W'(1);
            end
        end
        if (!s_clr) begin
            in_a_d = '0;
            in_b_d = '0;
        end

        // LDAC transfers the post-capture input values so a same-cycle write passes through.
        dac_a_d = dac_a_q;
        dac_b_d = dac_b_q;
        if (!s_ldac) begin
            dac_a_d = in_a_d;
            dac_b_d = in_b_d;
        end
        if (!s_clr) begin
            dac_a_d = '0;
            dac_b_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            in_a_q  <= '0;
            in_b_q  <= '0;
            dac_a_q <= '0;
            dac_b_q <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            in_a_q  <= in_a_d;
            in_b_q  <= in_b_d;
            dac_a_q <= dac_a_d;
            dac_b_q <= dac_b_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            done_q  <= capture;
            perr_q  <= abort;
        end
    end

    assign VoutA    = s_pd ? dac_a_q : '0;
    assign VoutB    = s_pd ? dac_b_q : '0;
    assign InA      = in_a_q;
    assign InB      = in_b_q;
    assign WrCntA   = cnt_a_q;
    assign WrCntB   = cnt_b_q;
    assign WrDone   = done_q;
    assign ProtoErr = perr_q;

endmodule
